// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin system bus arbiter.
// Provides access-type constants, the arbiter state enum and index width helper.
package bus_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic {
        IDLE,
        OWNED
    } arb_state_t;

    // Width of an owner index for n masters (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last, with wrap.
// Ports: req (request vector), last (previous owner) -> gnt (one-hot), idx, valid.
module rr_picker
    import bus_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int c;

    // Search order last+1, last+2, ... last+N (mod N); last itself is tried last.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(last) + i) % N;
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter sharing one memory/GPIO port among N_CORES masters,
// with optional hold-time preemption.
// Ports: clk, reset (async, active-high); per-core request/grant/wdata/address/rw;
// RAM_address/RAM_data_in/RAM_rw to memory, RAM_data_out broadcast as core_rdata;
// bus_busy (any grant) and bus_owner (registered owner index).
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter int N_CORES  = 2,
    parameter int DW       = 8,
    parameter int AW       = 9,
    parameter int MAX_HOLD = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CORES-1:0]      core_request,
    output logic [N_CORES-1:0]      core_grant,
    input  logic [N_CORES*DW-1:0]   core_wdata,
    input  logic [N_CORES*AW-1:0]   core_address,
    input  logic [N_CORES-1:0]      core_rw,
    output logic [DW-1:0]           core_rdata,
    output logic [AW-1:0]           RAM_address,
    output logic [DW-1:0]           RAM_data_in,
    input  logic [DW-1:0]           RAM_data_out,
    output logic                    RAM_rw,
    output logic                    bus_busy,
    output logic [$clog2(N_CORES)-1:0] bus_owner
);

    localparam int IW = idx_w(N_CORES);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam bit PREEMPT = (MAX_HOLD > 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'(PREEMPT ? MAX_HOLD - 1 : 0);

    arb_state_t    state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] last_owner, last_n;
    logic [HW-1:0] hold_cnt, hold_n;

    logic [N_CORES-1:0] own_oh;
    logic [N_CORES-1:0] pick_req;
    logic [N_CORES-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               granted;

    assign granted = (state == OWNED);

    always_comb begin
        own_oh        = '0;
        own_oh[owner] = granted;
    end

    // While owned, the picker only sees the other cores.
    assign pick_req = core_request & ~own_oh;

    rr_picker #(
        .N  (N_CORES),
        .IW (IW)
    ) u_picker (
        .req   (pick_req),
        .last  (last_owner),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(N_CORES - 1);
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_n;
            hold_cnt   <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last_owner;
        hold_n  = hold_cnt;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = OWNED;
                    owner_n = pick_idx;
                    last_n  = pick_idx;
                    hold_n  = '0;
                end
            end
            OWNED: begin
                if (!core_request[owner]) begin
                    hold_n = '0;
                    if (pick_valid) begin
                        owner_n = pick_idx;
                        last_n  = pick_idx;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (PREEMPT && hold_cnt >= HOLD_LAST && pick_valid) begin
                    owner_n = pick_idx;
                    last_n  = pick_idx;
                    hold_n  = '0;
                end else if (hold_cnt != '1) begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign core_grant = own_oh;
    assign bus_busy   = granted;
    assign bus_owner  = owner;
    assign core_rdata = RAM_data_out;

    // Idle bus drives zeros so memory never sees a stray write.
    assign RAM_address = granted ? core_address[owner*AW +: AW] : '0;
    assign RAM_data_in = granted ? core_wdata[owner*DW +: DW]   : '0;
    assign RAM_rw      = granted ? core_rw[owner]               : RW_READ;

    logic unused_ok;
    assign unused_ok = ^pick_gnt;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: three instances cover N=2, N=4, and
// N=3 with MAX_HOLD=3; a small memory model backs the N=2 instance.
module tb_bus_arbiter_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // N=2 default instance
    logic [1:0]  req2, gnt2, rw2;
    logic [15:0] wdata2;
    logic [17:0] addr2;
    logic [7:0]  rdata2, ram_din2, ram_dout2;
    logic [8:0]  ram_addr2;
    logic        ram_rw2, busy2;
    logic [0:0]  owner2;

    // N=4, no preemption
    logic [3:0]  req4, gnt4, rw4;
    logic [31:0] wdata4;
    logic [35:0] addr4;
    logic [7:0]  rdata4, ram_din4;
    logic [8:0]  ram_addr4;
    logic        ram_rw4, busy4;
    logic [1:0]  owner4;

    // N=3, MAX_HOLD=3
    logic [2:0]  req3, gnt3, rw3;
    logic [23:0] wdata3;
    logic [26:0] addr3;
    logic [7:0]  rdata3, ram_din3;
    logic [8:0]  ram_addr3;
    logic        ram_rw3, busy3;
    logic [1:0]  owner3;

    bus_arbiter_rr dut2 (
        .clk(clk), .reset(reset),
        .core_request(req2), .core_grant(gnt2),
        .core_wdata(wdata2), .core_address(addr2), .core_rw(rw2),
        .core_rdata(rdata2), .RAM_address(ram_addr2),
        .RAM_data_in(ram_din2), .RAM_data_out(ram_dout2),
        .RAM_rw(ram_rw2), .bus_busy(busy2), .bus_owner(owner2)
    );

    bus_arbiter_rr #(.N_CORES(4)) dut4 (
        .clk(clk), .reset(reset),
        .core_request(req4), .core_grant(gnt4),
        .core_wdata(wdata4), .core_address(addr4), .core_rw(rw4),
        .core_rdata(rdata4), .RAM_address(ram_addr4),
        .RAM_data_in(ram_din4), .RAM_data_out(8'h00),
        .RAM_rw(ram_rw4), .bus_busy(busy4), .bus_owner(owner4)
    );

    bus_arbiter_rr #(.N_CORES(3), .MAX_HOLD(3)) dut3 (
        .clk(clk), .reset(reset),
        .core_request(req3), .core_grant(gnt3),
        .core_wdata(wdata3), .core_address(addr3), .core_rw(rw3),
        .core_rdata(rdata3), .RAM_address(ram_addr3),
        .RAM_data_in(ram_din3), .RAM_data_out(8'h00),
        .RAM_rw(ram_rw3), .bus_busy(busy3), .bus_owner(owner3)
    );

    // gpiomem-like memory: synchronous write, read data one cycle after address
    logic [7:0] mem [512];
    always @(posedge clk) begin
        if (ram_rw2) mem[ram_addr2] <= ram_din2;
        ram_dout2 <= mem[ram_addr2];
    end

    // Grants must never be more than one-hot
    always @(negedge clk) begin
        if (!reset) begin
            n_tests++;
            assert ($onehot0(gnt2) && $onehot0(gnt4) && $onehot0(gnt3))
            else begin
                n_fail++;
                $error("FAIL onehot observed=%b/%b/%b expected=onehot0",
                       gnt2, gnt4, gnt3);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        reset  = 1'b1;
        req2   = '0; rw2 = '0; wdata2 = '0; addr2 = '0;
        req4   = '0; rw4 = '0; wdata4 = '0; addr4 = '0;
        req3   = '0; rw3 = '0; wdata3 = '0; addr3 = '0;
        #2;
        chk("rst_grant", 32'(gnt2), 32'h0);
        chk("rst_busy", 32'(busy2), 32'h0);
        chk("rst_owner", 32'(owner2), 32'h0);
        chk("rst_rw", 32'(ram_rw2), 32'h0);
        chk("rst_addr", 32'(ram_addr2), 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Handover: core0 holds 5 cycles, then core1 takes over
        addr2 = {9'h005, 9'h1F0};
        req2  = 2'b01;
        tick();
        chk("ho_grant0", 32'(gnt2), 32'h1);
        chk("ho_addr0", 32'(ram_addr2), 32'h1F0);
        chk("ho_busy", 32'(busy2), 32'h1);
        req2 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ho_hold0", 32'(gnt2), 32'h1);
        end
        req2 = 2'b10;
        tick();
        chk("ho_grant1", 32'(gnt2), 32'h2);
        chk("ho_addr1", 32'(ram_addr2), 32'h005);
        chk("ho_owner1", 32'(owner2), 32'h1);

        // Write then read through core1
        addr2[17:9]  = 9'h100;
        wdata2[15:8] = 8'hA5;
        rw2[1]       = 1'b1;
        #1;
        chk("wr_rw", 32'(ram_rw2), 32'h1);
        chk("wr_data", 32'(ram_din2), 32'hA5);
        chk("wr_addr", 32'(ram_addr2), 32'h100);
        tick();
        rw2[1] = 1'b0;
        #1;
        chk("rd_rw", 32'(ram_rw2), 32'h0);
        tick();
        chk("rd_data", 32'(rdata2), 32'hA5);

        // Reset mid-write drops grant immediately
        rw2[1] = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        chk("rmid_grant", 32'(gnt2), 32'h0);
        chk("rmid_rw", 32'(ram_rw2), 32'h0);
        chk("rmid_owner", 32'(owner2), 32'h0);
        req2 = 2'b11;
        tick();
        reset = 1'b0;
        tick();
        chk("rpost_first", 32'(gnt2), 32'h1);
        req2 = 2'b10;
        tick();
        chk("rpost_next", 32'(gnt2), 32'h2);

        // Idle safety: owner holds last value, core1 still presents a write
        req2 = 2'b00;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("idle_rw", 32'(ram_rw2), 32'h0);
            chk("idle_addr", 32'(ram_addr2), 32'h0);
            chk("idle_busy", 32'(busy2), 32'h0);
            chk("idle_owner", 32'(owner2), 32'h1);
            tick();
        end

        // Fairness on N=4: 0,1,2,3,0 back to back
        req4 = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("fair_grant", 32'(gnt4), 32'h1 << order[k]);
            chk("fair_busy", 32'(busy4), 32'h1);
            req4 = 4'hF & ~(4'h1 << order[k]);
            tick();
        end
        req4 = '0;

        // Preemption on N=3, MAX_HOLD=3
        addr3 = {9'h0AB, 9'h000, 9'h011};
        req3  = 3'b001;
        tick();
        chk("pre_c0_1", 32'(gnt3), 32'h1);
        req3 = 3'b101;
        tick();
        chk("pre_c0_2", 32'(gnt3), 32'h1);
        tick();
        chk("pre_c0_3", 32'(gnt3), 32'h1);
        tick();
        chk("pre_c2", 32'(gnt3), 32'h4);
        chk("pre_owner", 32'(owner3), 32'h2);
        chk("pre_addr", 32'(ram_addr3), 32'h0AB);
        tick();
        chk("pre_c2_hold", 32'(gnt3), 32'h4);
        req3 = 3'b001;
        tick();
        chk("pre_wrap", 32'(gnt3), 32'h1);
        chk("pre_addr0", 32'(ram_addr3), 32'h011);
        req3 = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Parametrised successor to the two-core system bus: N_CORES masters share one memory/GPIO port through a round-robin arbiter.
- Optional hold-time preemption stops one core from monopolising the bus.
- Sits between the core instances and gpiomem at top level.
- With N_CORES=2 and MAX_HOLD=0 it replaces the existing two-core bus directly.

Parameters:
- N_CORES, 2, number of masters (2..8).
- DW, 8, data width.
- AW, 9, address width.
- MAX_HOLD, 0, maximum consecutive granted cycles before preemption when another core is requesting. 0 disables preemption.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- core_request  input  N_CORES  per-core bus request, level.
- core_grant  output  N_CORES  one-hot or zero grant.
- core_wdata  input  N_CORES*DW  per-core write data; core i occupies bits [i*DW +: DW].
- core_address  input  N_CORES*AW  per-core address, packed the same way.
- core_rw  input  N_CORES  per-core access type; 1 = write, 0 = read.
- core_rdata  output  DW  RAM_data_out broadcast to all cores.
- RAM_address  output  AW  muxed address.
- RAM_data_in  output  DW  muxed write data.
- RAM_data_out  input  DW  memory read data.
- RAM_rw  output  1  muxed access type; forced 0 when no grant.
- bus_busy  output  1  high while any grant is active.
- bus_owner  output  $clog2(N_CORES)  index of the current owner; holds the last owner when idle.

Behaviour:
- Reset (asynchronous, immediate):
  - core_grant=0, bus_busy=0, bus_owner=0.
  - RAM_address=0, RAM_data_in=0, RAM_rw=0.
  - last_owner=N_CORES-1, so core 0 wins first; hold counter=0.
- Reset asserted mid-transfer drops the grant in the same cycle, with no completion.
- FSM states:
  - IDLE: no grant.
  - OWNED: exactly one grant bit high.
- IDLE -> OWNED:
  - Any core_request bit sampled high at edge t gives a registered grant at t+1.
  - Winner is the first requesting index searched from (last_owner+1) mod N_CORES upward with wrap.
- OWNED, stay: owner's request high and (MAX_HOLD==0, or hold_cnt < MAX_HOLD-1, or no other request). hold_cnt increments, saturating.
- OWNED, release: owner's request sampled low.
  - If other requests are pending, grant moves directly to the round-robin next core at t+1 (no idle gap).
  - Otherwise go to IDLE at t+1.
- OWNED, preempt: MAX_HOLD>0, the owner has been granted MAX_HOLD cycles, and another core is requesting.
  - Grant moves to the round-robin next core at the next edge.
  - The preempted core loses priority and must keep requesting to regain the bus.
- Any grant change: last_owner updates to the new owner and hold_cnt resets to 0.
- core_grant is never more than one-hot, in any cycle.
- A request seen only on an edge where the bus is owned waits; no request is ever lost while it is held high.
- Datapath mux (combinational from the registered owner):
  - RAM_address, RAM_data_in and RAM_rw select the owner's fields.
  - When no grant: address 0, data 0, rw 0, so there are no spurious writes.
  - core_rdata = RAM_data_out, unconditioned; a core uses it only while granted.
- Memory timing:
  - Write commits at the first edge after the grant is visible.
  - Read data is valid per gpiomem timing, one cycle after the address.
- bus_busy = |core_grant.
- bus_owner is the registered owner index.
- Widths:
  - hold_cnt is $clog2(MAX_HOLD+1) bits, minimum 1.
  - Index arithmetic wraps modulo N_CORES; non-power-of-2 N_CORES must wrap correctly (e.g. 2 -> 0 for N=3).

Decomposition:
- bus_pkg:
  - RW_READ/RW_WRITE constants.
  - arb_state_t enum {IDLE, OWNED}.
  - owner_idx width function.
- Sub-module rr_picker(N): given request vector and last_owner, returns a one-hot next grant plus its index and a valid flag. Purely combinational.

Test Plan:
- Reset: assert reset mid-grant with core1 writing -> core_grant=0 and RAM_rw=0 immediately; after release, core0 and core1 both requesting -> core0 granted first.
- Fairness: N=4, all requests held, each owner drops its request after 1 granted cycle -> grants in order 0,1,2,3,0 with no idle cycles between.
- Handover: N=2, core0 holds for 5 cycles then drops while core1 requests -> core1 grant at the next edge; RAM_address switches from core0's 0x1F0 to core1's 0x005.
- Preemption: MAX_HOLD=3, core0 holds continuously, core2 requests at cycle 1 -> core0 granted 3 cycles, then core2; core0 is regranted only after core2 drops.
- Idle safety: no requests for 10 cycles -> RAM_rw=0, RAM_address=0, bus_busy=0, bus_owner holds its last value.
- Write/read: core1 writes 0xA5 to 0x100, then reads 0x100 -> core_rdata=0xA5 one cycle after the read address is driven; one-hot assertion holds throughout.
